// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmit engine: serialises one byte per send request and pulses
// done_o for one cycle after the stop bit so the control register can clear send.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 1042,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       send_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  state_t           r_state, w_state_n;
  logic [CNT_W-1:0] r_cnt,   w_cnt_n;
  logic [2:0]       r_idx,   w_idx_n;
  logic [7:0]       r_shift, w_shift_n;
  logic             r_tx,    w_tx_n;
  logic             w_bit_end;

  // Handshake: send_i acts as "valid" and is only sampled in IDLE; done_o acts
  // as the acknowledge, high for exactly the DONE cycle, so the register clears
  // send at the edge that returns us to IDLE and the next IDLE cycle sees it low.
  assign w_bit_end = (r_cnt == LAST_CNT);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_idx   <= w_idx_n;
      r_shift <= w_shift_n;
      r_tx    <= w_tx_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_idx_n   = r_idx;
    w_shift_n = r_shift;
    w_tx_n    = r_tx;
    case (r_state)
      S_IDLE: begin
        w_tx_n  = 1'b1;
        w_cnt_n = '0;
        if (send_i) begin
          w_shift_n = data_i;
          w_state_n = S_START;
          w_tx_n    = 1'b0;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_cnt_n   = '0;
          w_idx_n   = '0;
          w_state_n = S_DATA;
          w_tx_n    = r_shift[0];
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_cnt_n   = '0;
          w_shift_n = r_shift >> 1;
          w_idx_n   = r_idx + 1'b1;
          // r_shift[1] is the bit that lands in position 0 after this shift.
          if (r_idx == 3'd7) begin
            w_state_n = S_STOP;
            w_tx_n    = 1'b1;
          end else begin
            w_tx_n = r_shift[1];
          end
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      S_STOP: begin
        w_tx_n = 1'b1;
        if (w_bit_end) begin
          w_cnt_n   = '0;
          w_state_n = S_DONE;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      S_DONE: begin
        w_tx_n    = 1'b1;
        w_state_n = S_IDLE;
      end
      default: begin
        w_tx_n    = 1'b1;
        w_cnt_n   = '0;
        w_state_n = S_IDLE;
      end
    endcase
  end

  assign tx_o    = r_tx;
  assign busy_o  = (r_state != S_IDLE);
  assign done_o  = (r_state == S_DONE);
  assign state_o = r_state;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: a fast instance (4 clocks/bit) wired to
// a control-register model, plus a default-rate instance for the full-speed frame.
`timescale 1ns/1ps
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data4 = 8'h00;
  logic       tx4, busy4, done4;
  logic [2:0] st4;
  logic       send_d = 1'b0;
  logic [7:0] data_d = 8'hFF;
  logic       tx_d, busy_d, done_d;
  logic [2:0] st_d;

  // control register model: clear (we_2 = done_o) has priority over CPU write
  logic q = 1'b0;
  logic we1 = 1'b0;
  logic d1 = 1'b0;
  logic clr_en = 1'b1;

  int n_assert = 0;
  int n_fail = 0;

  always #50 clk = ~clk;

  always @(posedge clk) begin
    if (clr_en && done4) q <= 1'b0;
    else if (we1)        q <= d1;
  end

  uart_tx_serializer #(.CLKS_PER_BIT(4)) u_dut4 (
    .clk_i(clk), .reset_i(rst), .send_i(q), .data_i(data4),
    .tx_o(tx4), .busy_o(busy4), .done_o(done4), .state_o(st4)
  );

  uart_tx_serializer u_dut (
    .clk_i(clk), .reset_i(rst), .send_i(send_d), .data_i(data_d),
    .tx_o(tx_d), .busy_o(busy_d), .done_o(done_d), .state_o(st_d)
  );

  task automatic chk(input string tag, input int k, input logic got, input logic exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s k=%0d got=%0b exp=%0b", tag, k, got, exp);
    end
  endtask

  task automatic chk3(input string tag, input int k, input logic [2:0] got, input logic [2:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s k=%0d got=%0d exp=%0d", tag, k, got, exp);
    end
  endtask

  // expected line level in cycle k (1-based) after the start edge
  function automatic logic exp_tx(input logic [7:0] d, input int k, input int cpb);
    int b;
    b = (k - 1) / cpb;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    return 1'b1;
  endfunction

  // CPU sets send; returns at the negedge of cycle 1 of the frame
  task automatic cpu_send(input logic [7:0] d);
    data4 = d;
    we1 = 1'b1; d1 = 1'b1;
    @(negedge clk);
    we1 = 1'b0;
    chk("pre_start_busy", 0, busy4, 1'b0);
    @(negedge clk);
  endtask

  // called at the negedge of cycle 1; checks cycles 1..last_k
  task automatic check_frame(input string tn, input logic [7:0] d, input int last_k,
                             input int chg_at, input bit wr_at_done);
    for (int k = 1; k <= last_k; k++) begin
      if (k > 1) @(negedge clk);
      if (k == chg_at) data4 = 8'hFF;
      if (k <= 40) begin
        chk({tn, "_tx"},   k, tx4,   exp_tx(d, k, 4));
        chk({tn, "_busy"}, k, busy4, 1'b1);
        chk({tn, "_done"}, k, done4, 1'b0);
      end else begin
        chk({tn, "_tx_done"},   k, tx4,   1'b1);
        chk({tn, "_busy_done"}, k, busy4, 1'b1);
        chk({tn, "_done_pulse"}, k, done4, 1'b1);
        chk3({tn, "_state_done"}, k, st4, 3'd4);
        if (wr_at_done) begin we1 = 1'b1; d1 = 1'b1; end
      end
    end
  endtask

  task automatic check_idle(input string tn, input logic exp_q);
    chk({tn, "_idle_tx"},   0, tx4,   1'b1);
    chk({tn, "_idle_busy"}, 0, busy4, 1'b0);
    chk({tn, "_idle_done"}, 0, done4, 1'b0);
    chk({tn, "_idle_q"},    0, q,     exp_q);
  endtask

  initial begin
    int lows, dones;
    // reset
    repeat (2) @(negedge clk);
    chk("rst_tx4", 0, tx4, 1'b1);
    chk("rst_busy4", 0, busy4, 1'b0);
    chk("rst_done4", 0, done4, 1'b0);
    chk3("rst_state4", 0, st4, 3'd0);
    chk("rst_tx_d", 0, tx_d, 1'b1);
    chk("rst_busy_d", 0, busy_d, 1'b0);
    chk3("rst_state_d", 0, st_d, 3'd0);
    rst = 1'b0;

    // 1: 0x55 with clear on done
    cpu_send(8'h55);
    check_frame("t1", 8'h55, 41, 0, 1'b0);
    @(negedge clk); check_idle("t1", 1'b0);
    @(negedge clk); chk("t1_no_retrigger", 0, busy4, 1'b0);

    // 2: data changes mid-frame
    cpu_send(8'hA3);
    check_frame("t2", 8'hA3, 41, 10, 1'b0);
    @(negedge clk); check_idle("t2", 1'b0);

    // 3: send held, no clear -> back-to-back frames with 1 idle cycle
    clr_en = 1'b0;
    cpu_send(8'h3C);
    check_frame("t3a", 8'h3C, 41, 0, 1'b0);
    @(negedge clk); check_idle("t3gap", 1'b1);
    chk3("t3gap_state", 0, st4, 3'd0);
    @(negedge clk);
    check_frame("t3b", 8'h3C, 41, 0, 1'b0);
    we1 = 1'b1; d1 = 1'b0;
    @(negedge clk); we1 = 1'b0;
    check_idle("t3end", 1'b0);
    @(negedge clk); chk("t3_stays_idle", 0, busy4, 1'b0);
    clr_en = 1'b1;

    // 4: reset during data bit 3 of 0x00
    cpu_send(8'h00);
    check_frame("t4a", 8'h00, 18, 0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_idle("t4rst", 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check_frame("t4b", 8'h00, 41, 0, 1'b0);
    @(negedge clk); check_idle("t4end", 1'b0);

    // 6: CPU write coincident with done still leaves send cleared
    cpu_send(8'h81);
    check_frame("t6", 8'h81, 41, 0, 1'b1);
    @(negedge clk); we1 = 1'b0;
    check_idle("t6", 1'b0);
    @(negedge clk); chk("t6_no_retrigger", 0, busy4, 1'b0);

    // 5: default rate, 0xFF
    send_d = 1'b1;
    @(negedge clk);
    lows = 0; dones = 0;
    for (int k = 1; k <= 10421; k++) begin
      if (k > 1) @(negedge clk);
      if (tx_d == 1'b0) lows++;
      if (done_d == 1'b1) dones++;
      chk("t5_busy", k, busy_d, 1'b1);
      if (k <= 10420) begin
        chk("t5_tx", k, tx_d, exp_tx(8'hFF, k, 1042));
        chk("t5_done", k, done_d, 1'b0);
      end else begin
        chk("t5_done_pulse", k, done_d, 1'b1);
        chk("t5_tx_done", k, tx_d, 1'b1);
        send_d = 1'b0;
      end
    end
    n_assert++;
    assert (lows == 1042) else begin
      n_fail++; $error("FAIL t5_low_cycles got=%0d exp=1042", lows);
    end
    n_assert++;
    assert (dones == 1) else begin
      n_fail++; $error("FAIL t5_done_count got=%0d exp=1", dones);
    end
    @(negedge clk);
    chk("t5_idle_busy", 0, busy_d, 1'b0);
    chk("t5_idle_done", 0, done_d, 1'b0);
    chk("t5_idle_tx", 0, tx_d, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
